// File: rtl/addr_reg_arbiter.sv
// Round-robin owner of the shared address register: grants one core, loads its
// base address, steps it once per completed memory beat, then releases.
module addr_reg_arbiter #(
   parameter int NUM_CORES = 8,
   parameter int ADDR_W    = 16,
   parameter int LEN_W     = 4,
   localparam int ID_W     = $clog2(NUM_CORES)
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [NUM_CORES-1:0]        req,
   input  logic [NUM_CORES*ADDR_W-1:0] base_addr,
   input  logic [NUM_CORES*LEN_W-1:0]  burst_len,
   input  logic                        mem_done,
   output logic                        ar_write,
   output logic [ADDR_W-1:0]           ar_data,
   output logic [NUM_CORES-1:0]        gnt,
   output logic [ID_W-1:0]             gnt_id,
   output logic                        busy,
   output logic                        xfer_done
);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_LOAD    = 2'd1,
      S_WAIT    = 2'd2,
      S_RELEASE = 2'd3
   } state_t;

   state_t                state_q, state_d;
   logic [ID_W-1:0]       rr_ptr_q, rr_ptr_d;
   logic [LEN_W-1:0]      beats_left_q, beats_left_d;
   logic [ADDR_W-1:0]     cur_addr_q, cur_addr_d;
   logic [NUM_CORES-1:0]  gnt_q, gnt_d;
   logic [ID_W-1:0]       gnt_id_q, gnt_id_d;
   logic                  busy_q, busy_d;
   logic                  ar_write_q, ar_write_d;
   logic [ADDR_W-1:0]     ar_data_q, ar_data_d;
   logic                  xfer_done_q, xfer_done_d;

   logic                  found_s;
   logic [ID_W-1:0]       sel_s;
   logic [ID_W-1:0]       cand_s;
   logic [ADDR_W-1:0]     sel_base_s;
   logic [LEN_W-1:0]      sel_len_s;

   // Round-robin search starting at rr_ptr; first hit wins.
   always_comb begin
      found_s = 1'b0;
      sel_s   = rr_ptr_q;
      cand_s  = rr_ptr_q;
      for (int i = 0; i < NUM_CORES; i++) begin
         cand_s = rr_ptr_q + ID_W'(i);
         if (!found_s && req[cand_s]) begin
            found_s = 1'b1;
            sel_s   = cand_s;
         end else begin
            found_s = found_s;
         end
      end
      sel_base_s = base_addr[sel_s*ADDR_W +: ADDR_W];
      sel_len_s  = burst_len[sel_s*LEN_W +: LEN_W];
   end

   // Next-state and next-output logic; outputs are computed one edge early so they leave registered.
   always_comb begin
      state_d      = state_q;
      rr_ptr_d     = rr_ptr_q;
      beats_left_d = beats_left_q;
      cur_addr_d   = cur_addr_q;
      gnt_d        = gnt_q;
      gnt_id_d     = gnt_id_q;
      busy_d       = busy_q;
      ar_write_d   = 1'b0;
      ar_data_d    = ar_data_q;
      xfer_done_d  = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (found_s) begin
               state_d      = S_LOAD;
               gnt_d        = {{(NUM_CORES-1){1'b0}}, 1'b1} << sel_s;
               gnt_id_d     = sel_s;
               busy_d       = 1'b1;
               cur_addr_d   = sel_base_s;
               beats_left_d = (sel_len_s == {LEN_W{1'b0}}) ? LEN_W'(1) : sel_len_s;
               ar_write_d   = 1'b1;
               ar_data_d    = sel_base_s;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_LOAD: begin
            state_d = S_WAIT;
         end
         S_WAIT: begin
            if (mem_done) begin
               if (beats_left_q > LEN_W'(1)) begin
                  state_d      = S_LOAD;
                  cur_addr_d   = cur_addr_q + ADDR_W'(1);
                  beats_left_d = beats_left_q - LEN_W'(1);
                  ar_write_d   = 1'b1;
                  ar_data_d    = cur_addr_q + ADDR_W'(1);
               end else begin
                  state_d     = S_RELEASE;
                  xfer_done_d = 1'b1;
               end
            end else begin
               state_d = S_WAIT;
            end
         end
         S_RELEASE: begin
            state_d  = S_IDLE;
            rr_ptr_d = gnt_id_q + ID_W'(1);
            gnt_d    = {NUM_CORES{1'b0}};
            gnt_id_d = {ID_W{1'b0}};
            busy_d   = 1'b0;
         end
         default: begin
            state_d      = S_IDLE;
            beats_left_d = {LEN_W{1'b0}};
            gnt_d        = {NUM_CORES{1'b0}};
            gnt_id_d     = {ID_W{1'b0}};
            busy_d       = 1'b0;
         end
      endcase
   end

   // State and output registers; reset aborts any transfer silently.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= S_IDLE;
         rr_ptr_q     <= {ID_W{1'b0}};
         beats_left_q <= {LEN_W{1'b0}};
         cur_addr_q   <= {ADDR_W{1'b0}};
         gnt_q        <= {NUM_CORES{1'b0}};
         gnt_id_q     <= {ID_W{1'b0}};
         busy_q       <= 1'b0;
         ar_write_q   <= 1'b0;
         ar_data_q    <= {ADDR_W{1'b0}};
         xfer_done_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         rr_ptr_q     <= rr_ptr_d;
         beats_left_q <= beats_left_d;
         cur_addr_q   <= cur_addr_d;
         gnt_q        <= gnt_d;
         gnt_id_q     <= gnt_id_d;
         busy_q       <= busy_d;
         ar_write_q   <= ar_write_d;
         ar_data_q    <= ar_data_d;
         xfer_done_q  <= xfer_done_d;
      end
   end

   assign ar_write  = ar_write_q;
   assign ar_data   = ar_data_q;
   assign gnt       = gnt_q;
   assign gnt_id    = gnt_id_q;
   assign busy      = busy_q;
   assign xfer_done = xfer_done_q;

endmodule

// File: tb/tb_addr_reg_arbiter.sv
// Scoreboard bench for addr_reg_arbiter: directed transfers push expected
// address-register writes and completions; a negedge monitor pops and compares.
module tb_addr_reg_arbiter;
   localparam int N  = 8;
   localparam int AW = 16;
   localparam int LW = 4;

   logic            clk = 1'b0;
   logic            rst = 1'b0;
   logic [N-1:0]    req = '0;
   logic [N*AW-1:0] base_addr = '0;
   logic [N*LW-1:0] burst_len = '0;
   logic            mem_done = 1'b0;
   logic            ar_write;
   logic [AW-1:0]   ar_data;
   logic [N-1:0]    gnt;
   logic [2:0]      gnt_id;
   logic            busy;
   logic            xfer_done;

   addr_reg_arbiter dut (
      .clk(clk), .rst(rst), .req(req), .base_addr(base_addr), .burst_len(burst_len),
      .mem_done(mem_done), .ar_write(ar_write), .ar_data(ar_data), .gnt(gnt),
      .gnt_id(gnt_id), .busy(busy), .xfer_done(xfer_done)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit          is_done;
      logic [15:0] addr;
      logic [2:0]  id;
   } ev_t;

   ev_t exp_q[$];
   ev_t mon_e;
   int  n_vec = 0;
   int  n_err = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
      n_vec++;
      if (act !== expv) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, expv, $time);
      end
   endtask

   // Monitor: every write strobe or completion must match the next expected event.
   always @(negedge clk) begin
      check("busy_eq_any_gnt", {31'd0, busy}, {31'd0, |gnt});
      if (ar_write || xfer_done) begin
         if (exp_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL unexpected_event: got ar_write=%0b xfer_done=%0b ar_data=0x%0h, expected none",
                     ar_write, xfer_done, ar_data);
         end else begin
            mon_e = exp_q.pop_front();
            check("event_is_done", {31'd0, xfer_done}, {31'd0, mon_e.is_done});
            check("event_is_write", {31'd0, ar_write}, {31'd0, !mon_e.is_done});
            if (!mon_e.is_done) check("ar_data", {16'd0, ar_data}, {16'd0, mon_e.addr});
            check("event_gnt_id", {29'd0, gnt_id}, {29'd0, mon_e.id});
            check("event_gnt", {24'd0, gnt}, {24'd0, 8'h01 << mon_e.id});
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic set_core(input int c, input logic [15:0] b, input logic [3:0] l);
      base_addr[c*AW +: AW] = b;
      burst_len[c*LW +: LW] = l;
   endtask

   task automatic expect_beats(input int c, input logic [15:0] b, input int n);
      for (int k = 0; k < n; k++)
         exp_q.push_back('{is_done: 1'b0, addr: b + 16'(k), id: 3'(c)});
   endtask

   task automatic expect_done(input int c);
      exp_q.push_back('{is_done: 1'b1, addr: 16'h0000, id: 3'(c)});
   endtask

   task automatic wait_grant(input int exp_id);
      int cyc = 0;
      while (!busy && cyc < 30) begin
         tick;
         cyc++;
      end
      check("grant_seen", {31'd0, busy}, 32'd1);
      if (busy) begin
         check("gnt_id", {29'd0, gnt_id}, 32'(exp_id));
         check("gnt", {24'd0, gnt}, {24'd0, 8'h01 << exp_id});
      end
   endtask

   // Starts in the LOAD cycle; ends right after the edge that consumed mem_done.
   task automatic beat(input int dly);
      tick;
      repeat (dly) tick;
      mem_done = 1'b1;
      tick;
      mem_done = 1'b0;
   endtask

   task automatic run_xfer(input int c, input logic [15:0] b, input int nbeats, input int dly);
      expect_beats(c, b, nbeats);
      expect_done(c);
      wait_grant(c);
      repeat (nbeats) beat(dly);
      check("xfer_done_pulse", {31'd0, xfer_done}, 32'd1);
      tick;
      check("busy_after_release", {31'd0, busy}, 32'd0);
      check("gnt_after_release", {24'd0, gnt}, 32'd0);
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_gnt"}, {24'd0, gnt}, 32'd0);
      check({tag, "_gnt_id"}, {29'd0, gnt_id}, 32'd0);
      check({tag, "_busy"}, {31'd0, busy}, 32'd0);
      check({tag, "_ar_write"}, {31'd0, ar_write}, 32'd0);
      check({tag, "_ar_data"}, {16'd0, ar_data}, 32'd0);
      check({tag, "_xfer_done"}, {31'd0, xfer_done}, 32'd0);
   endtask

   task automatic do_reset;
      rst = 1'b0;
      req = '0;
      mem_done = 1'b0;
      repeat (2) tick;
      check_all_zero("reset");
      rst = 1'b1;
   endtask

   initial begin
      do_reset();

      // Single beat on core 3, grant latency and mem_done three cycles after grant.
      set_core(3, 16'h1000, 4'd1);
      expect_beats(3, 16'h1000, 1);
      expect_done(3);
      req = 8'h08;
      tick;
      check("single_latency_busy", {31'd0, busy}, 32'd1);
      check("single_ar_write", {31'd0, ar_write}, 32'd1);
      check("single_ar_data", {16'd0, ar_data}, 32'h1000);
      wait_grant(3);
      req = 8'h00;
      tick;
      check("single_ar_write_1cyc", {31'd0, ar_write}, 32'd0);
      tick;
      tick;
      mem_done = 1'b1;
      tick;
      mem_done = 1'b0;
      check("single_xfer_done", {31'd0, xfer_done}, 32'd1);
      check("single_busy_in_release", {31'd0, busy}, 32'd1);
      tick;
      check("single_xfer_done_1cyc", {31'd0, xfer_done}, 32'd0);
      check("single_busy_off", {31'd0, busy}, 32'd0);

      // Burst with address wrap on core 0.
      set_core(0, 16'hFFFE, 4'd3);
      req = 8'h01;
      run_xfer(0, 16'hFFFE, 3, 1);
      req = 8'h00;

      // Round robin from a fresh pointer with all cores requesting.
      do_reset();
      for (int i = 0; i < N; i++) set_core(i, 16'(i * 256 + 16'h0010), 4'd1);
      req = 8'hFF;
      for (int g = 0; g < 14; g++) run_xfer(g % N, 16'((g % N) * 256 + 16'h0010), 1, 0);
      req = 8'h24;
      run_xfer(2, 16'h0210, 1, 0);
      run_xfer(5, 16'h0510, 1, 0);
      req = 8'h00;

      // Stray mem_done in IDLE, then burst_len 0 acting as one beat.
      mem_done = 1'b1;
      tick;
      mem_done = 1'b0;
      tick;
      check("stray_idle_busy", {31'd0, busy}, 32'd0);
      check("stray_idle_ar_write", {31'd0, ar_write}, 32'd0);
      set_core(7, 16'h7777, 4'd0);
      req = 8'h80;
      run_xfer(7, 16'h7777, 1, 0);
      req = 8'h00;

      // Stray mem_done during LOAD must not count as a beat.
      set_core(2, 16'h2000, 4'd2);
      expect_beats(2, 16'h2000, 2);
      expect_done(2);
      req = 8'h04;
      wait_grant(2);
      req = 8'h00;
      mem_done = 1'b1;
      tick;
      mem_done = 1'b0;
      repeat (3) tick;
      check("stray_load_no_write", {31'd0, ar_write}, 32'd0);
      check("stray_load_still_busy", {31'd0, busy}, 32'd1);
      mem_done = 1'b1;
      tick;
      mem_done = 1'b0;
      beat(0);
      check("stray_load_done", {31'd0, xfer_done}, 32'd1);
      tick;

      // Asynchronous reset in the middle of a 5-beat burst on core 4.
      set_core(4, 16'h4000, 4'd5);
      expect_beats(4, 16'h4000, 3);
      req = 8'h10;
      wait_grant(4);
      beat(0);
      beat(0);
      tick;
      rst = 1'b0;
      #1;
      check_all_zero("midreset");
      repeat (2) tick;
      check("midreset_queue_empty", 32'(exp_q.size()), 32'd0);
      rst = 1'b1;
      run_xfer(4, 16'h4000, 5, 0);
      req = 8'h00;

      // Granted core drops req after LOAD; both beats still complete.
      set_core(1, 16'h1230, 4'd2);
      expect_beats(1, 16'h1230, 2);
      expect_done(1);
      req = 8'h02;
      wait_grant(1);
      tick;
      req = 8'h00;
      check("drop_wait_ar_write", {31'd0, ar_write}, 32'd0);
      check("drop_wait_ar_data_hold", {16'd0, ar_data}, 32'h1230);
      mem_done = 1'b1;
      tick;
      mem_done = 1'b0;
      beat(1);
      check("drop_xfer_done", {31'd0, xfer_done}, 32'd1);
      tick;
      check("drop_busy_off", {31'd0, busy}, 32'd0);

      repeat (5) tick;
      check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
